// File: rtl/galaxian_pkg.sv
// Shared types and helpers for the Galaxian playfield blocks.
//   slot_state_t : per-shot slot state (IDLE / FLYING)
//   coord_t      : 10-bit screen coordinate
//   abs_diff     : unsigned |a - b| without wrap-around
package galaxian_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } slot_state_t;

  typedef logic [9:0] coord_t;

  localparam int NUM_SLOTS    = 2;
  localparam int SCREEN_Y_MAX = 287;

  // Subtracting the smaller operand from the larger one keeps the result
  // non-negative, so no wrap-around can happen.
  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/galaxian_lfsr8.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1. It advances every clock.
// It is shared by the enemy missile fire decision and the alien AI.
//   clk   : clock
//   rst_n : asynchronous active-low reset; loads SEED
//   value : current LFSR state. It is never 0 when SEED is nonzero.
module galaxian_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] value
);

  // Feedback mask for x^6, x^5, x^4 and x^0. Bit 0 receives the shifted-out MSB.
  localparam logic [7:0] TAPS = 8'h71;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      value <= {value[6:0], 1'b0} ^ (value[7] ? TAPS : 8'h00);
    end
  end

endmodule

// File: rtl/enemy_missile.sv
// Enemy (alien) missile block. It manages two independent downward-falling
// shot slots, a launch cooldown, a pseudo-random fire decision, and
// ship hit detection.
//   frame_clk      : frame-rate clock
//   Reset          : asynchronous active-low reset
//   fire_enable    : allows new launches; shots already in flight keep falling
//   alien_valid    : a live shooter alien is selected
//   ALIEN_X/Y      : centre of the shooter alien
//   SHIPX/Y        : centre of the ship
//   ship_alive     : when 0, hit detection is disabled
//   EMISSILE1/2_X/Y: slot positions; each holds its last value while the slot is idle
//   emissile_1/2   : slot is FLYING
//   ship_hit       : one-frame pulse for each hit event
module enemy_missile
  import galaxian_pkg::*;
#(
  parameter int         STEP        = 4,
  parameter int         Y_MAX       = SCREEN_Y_MAX,
  parameter int         SPAWN_DY    = 8,
  parameter int         COOLDOWN    = 30,
  parameter int         FIRE_THRESH = 63,
  parameter int         HIT_HALF_W  = 6,
  parameter int         HIT_HALF_H  = 4,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire_enable,
  input  logic       alien_valid,
  input  logic [9:0] ALIEN_X,
  input  logic [9:0] ALIEN_Y,
  input  logic [9:0] SHIPX,
  input  logic [9:0] SHIPY,
  input  logic       ship_alive,
  output logic [9:0] EMISSILE1_X,
  output logic [9:0] EMISSILE1_Y,
  output logic [9:0] EMISSILE2_X,
  output logic [9:0] EMISSILE2_Y,
  output logic       emissile_1,
  output logic       emissile_2,
  output logic       ship_hit
);

  localparam int          CD_W    = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [7:0]  THRESH  = 8'(FIRE_THRESH);
  localparam logic [10:0] Y_LIMIT = 11'(Y_MAX);

  logic [7:0]                 lfsr;
  logic [CD_W-1:0]            cooldown;
  logic [NUM_SLOTS-1:0]       flying;
  logic [NUM_SLOTS-1:0]       idle;
  logic [NUM_SLOTS-1:0]       hit_now;
  logic [NUM_SLOTS-1:0]       lowest_idle;
  logic [NUM_SLOTS-1:0]       launch_sel;
  coord_t [NUM_SLOTS-1:0]     pos_x;
  coord_t [NUM_SLOTS-1:0]     pos_y;
  logic [10:0]                spawn_sum;
  logic                       launch_ok;

  galaxian_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (frame_clk),
    .rst_n (Reset),
    .value (lfsr)
  );

  // The spawn point is compared at 11 bits, so a launch near the bottom cannot wrap.
  assign spawn_sum = {1'b0, ALIEN_Y} + 11'(SPAWN_DY);
  assign idle      = ~flying;

  // The launch decision uses registered slot state. A slot that retires on
  // this edge is still FLYING here, so it can only be reused on the next edge.
  assign launch_ok = (cooldown == '0) && fire_enable && alien_valid &&
                     (lfsr <= THRESH) && (spawn_sum < Y_LIMIT) && (|idle);

  // Isolate the lowest set bit: the lowest-index idle slot takes the launch.
  assign lowest_idle = idle & (~idle + NUM_SLOTS'(1));
  assign launch_sel  = launch_ok ? lowest_idle : '0;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    slot_state_t state;
    coord_t      x;
    coord_t      y;
    logic [10:0] next_y_sum;

    assign next_y_sum = {1'b0, y} + 11'(STEP);
    assign hit_now[i] = (state == FLYING) && ship_alive &&
                        (abs_diff(x, SHIPX) <= coord_t'(HIT_HALF_W)) &&
                        (abs_diff(y, SHIPY) <= coord_t'(HIT_HALF_H));

    // A hit takes priority over retirement. A retiring or hit shot keeps
    // its last position so the sprite mapper sees a stable value.
    always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
        // NOTE: positions are reset as well, so the outputs read 0 (not X) out of reset.
        state <= IDLE;
        x     <= '0;
        y     <= '0;
      end else if (state == FLYING) begin
        if (hit_now[i] || (next_y_sum >= Y_LIMIT)) begin
          state <= IDLE;
        end else begin
          y <= next_y_sum[9:0];
        end
      end else if (launch_sel[i]) begin
        state <= FLYING;
        x     <= ALIEN_X;
        y     <= spawn_sum[9:0];
      end
    end

    assign flying[i] = (state == FLYING);
    assign pos_x[i]  = x;
    assign pos_y[i]  = y;
  end

  // Cooldown reloads on a launch and otherwise counts down to zero. A launch
  // at edge n therefore allows the next launch no earlier than edge n+COOLDOWN+1.
  // Simultaneous hits from both slots collapse into a single ship_hit pulse.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      cooldown <= '0;
      ship_hit <= 1'b0;
    end else begin
      ship_hit <= |hit_now;
      if (|launch_sel) begin
        cooldown <= CD_W'(COOLDOWN);
      end else if (cooldown != '0) begin
        cooldown <= cooldown - CD_W'(1);
      end
    end
  end

  assign EMISSILE1_X = pos_x[0];
  assign EMISSILE1_Y = pos_y[0];
  assign EMISSILE2_X = pos_x[1];
  assign EMISSILE2_Y = pos_y[1];
  assign emissile_1  = flying[0];
  assign emissile_2  = flying[1];

endmodule
